serial_parity_checker: RTL and testbench
========================================

Name: serial_parity_checker

Overview:
- Consumes a serial bit stream one bit per valid cycle and XOR-accumulates DATA_W data bits, then compares the accumulated value against a trailing parity bit.
- Sits downstream of the single-bit xor_gate primitive and applies that XOR operation sequentially across a frame.
- Reports the reassembled data word, the computed even parity and a pass/fail flag for each frame.

Parameters:
- DATA_W, 8, number of data bits per frame (>=1), received LSB first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- bit_valid  input  1  bit_in is sampled this cycle.
- bit_in  input  1  serial data or parity bit.
- frame_abort  input  1  discards the frame in progress and returns to IDLE.
- busy  output  1  high while in DATA or PARITY state.
- done  output  1  one-cycle pulse when a frame completes.
- parity_ok  output  1  1 when the received parity matches the computed parity; valid with done, held until the next done.
- calc_parity  output  1  XOR of the DATA_W data bits (even parity); valid with done, held until the next done.
- data_out  output  DATA_W  collected data, first received bit at [0]; valid with done, held until the next done.
- err_cnt  output  8  saturating parity-error count (present only with ERR_CNT_EN).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high and has priority over all other inputs.
- Reset values: state=IDLE, busy=0, done=0, parity_ok=0, calc_parity=0, data_out=0, accumulator=0, bit counter=0, err_cnt=0.
- Input sampling: an input bit is consumed only when bit_valid=1. Idle cycles inside a frame hold all state unchanged; gaps of any length are legal.
- State machine (2-bit state):
  - IDLE:
    - On bit_valid: shift register bit 0 takes bit_in, acc=bit_in, cnt=1.
    - Next state is DATA, or PARITY when DATA_W==1.
  - DATA:
    - On bit_valid: data bit cnt takes bit_in, acc^=bit_in, cnt++.
    - When the accepted bit has cnt==DATA_W-1 before the increment, next state is PARITY.
  - PARITY:
    - On bit_valid: next state is IDLE.
    - Registered in the same edge: data_out=shift register, calc_parity=acc, parity_ok=(acc==bit_in), done=1.
- Latency: done asserts in the cycle after the edge that samples the parity bit. It is high for exactly one cycle.
- Back-to-back frames: a bit presented while done=1 is accepted as bit 0 of the next frame, since the state is already IDLE. No dead cycle is required between frames.
- frame_abort:
  - In any state it forces IDLE and clears acc and cnt. A bit_valid in the same cycle is discarded.
  - No done pulse is produced. data_out, calc_parity and parity_ok keep their previous values.
  - Abort while in IDLE is a no-op.
- busy: 1 exactly when state is DATA or PARITY. It is combinational from the state register.
- Reset mid-frame: the partial frame is lost, no done pulse is produced, and all outputs return to their reset values.
- Width rule: the bit counter is $clog2(DATA_W+1) bits wide, with a minimum width of 1.

Optional Feature:
- Macro: ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt[7:0].
  - err_cnt increments on the edge where done is set with a parity mismatch.
  - Saturates at 8'hFF.
  - Cleared only by rst.
- Undefined: the err_cnt port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package parity_pkg holds:
  - State encodings: ST_IDLE=2'b00, ST_DATA=2'b01, ST_PARITY=2'b10.
  - ERR_CNT_W=8.
  - ERR_CNT_MAX=8'hFF.
- One natural sub-module, xor_accum: a 1-bit register with synchronous clear, load and XOR-enable. It is instantiated for the running parity and reused by later CRC/LFSR stages.

Test Plan:
- DATA_W=8, send 8'hA5 LSB first (bits 1,0,1,0,0,1,0,1), then parity 0 -> one done pulse one cycle after the parity bit; data_out=8'hA5, calc_parity=0, parity_ok=1, busy low from the same cycle as done.
- Send 8'h07 with parity 0 (wrong; correct is 1) -> done, calc_parity=1, parity_ok=0, err_cnt=1 (with ERR_CNT_EN).
- Send 8'h3C with 3 idle cycles between bits, then parity 0 -> results identical to a gapless frame: data_out=8'h3C, parity_ok=1.
- Send 4 bits of 8'hFF, assert frame_abort together with bit_valid, then send full frame 8'h81 with parity 0 -> no done for the aborted frame; next done gives data_out=8'h81, parity_ok=1.
- Send 5 bits, then pulse rst for one cycle, then send 8'hA5 with parity 0 -> all outputs are 0 after reset; next frame is correct, parity_ok=1.
- With ERR_CNT_EN, send 260 back-to-back bad-parity frames with no gap (next bit presented during done) -> 260 done pulses; err_cnt=8'hFF and holds.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity checker and later
// CRC/LFSR stages built on the same primitives.
package parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DATA   = 2'b01,
    ST_PARITY = 2'b10
  } state_t;

  localparam int unsigned ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

endpackage : parity_pkg

// File: rtl/xor_accum.sv
// One-bit XOR accumulator: synchronous clear, load and XOR-enable.
// Priority is rst > clr > load > xor_en.
module xor_accum (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic load_val,
  input  logic xor_en,
  input  logic xor_in,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= 1'b0;
    end else if (load) begin
      q <= load_val;
    end else if (xor_en) begin
      q <= q ^ xor_in;
    end
  end

endmodule : xor_accum

// File: rtl/serial_parity_checker.sv
// Collects DATA_W serial data bits (LSB first) plus a trailing even-parity
// bit and reports data, computed parity and match. `define ERR_CNT_EN adds err_cnt.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              frame_abort,
  output logic              busy,
  output logic              done,
  output logic              parity_ok,
  output logic              calc_parity,
  output logic [DATA_W-1:0] data_out
`ifdef ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int unsigned CNT_RAW = $clog2(DATA_W + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                done_nxt, calc_nxt, ok_nxt;
  logic                acc, acc_clr, acc_load, acc_xor;

  xor_accum u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .load     (acc_load),
    .load_val (bit_in),
    .xor_en   (acc_xor),
    .xor_in   (bit_in),
    .q        (acc)
  );

  assign busy = (state == ST_DATA) || (state == ST_PARITY);

  // State and frame registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      done        <= 1'b0;
      parity_ok   <= 1'b0;
      calc_parity <= 1'b0;
      data_out    <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      shreg       <= shreg_nxt;
      done        <= done_nxt;
      parity_ok   <= ok_nxt;
      calc_parity <= calc_nxt;
      data_out    <= data_nxt;
    end
  end

  // Next-state and result logic; abort wins over any bit in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    data_nxt  = data_out;
    calc_nxt  = calc_parity;
    ok_nxt    = parity_ok;
    done_nxt  = 1'b0;
    acc_clr   = 1'b0;
    acc_load  = 1'b0;
    acc_xor   = 1'b0;

    if (frame_abort) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      acc_clr   = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bit_valid) begin
            shreg_nxt = DATA_W'(bit_in);
            acc_load  = 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = (DATA_W == 1) ? ST_PARITY : ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_valid) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
              if (cnt == CNT_W'(i)) shreg_nxt[i] = bit_in;
            end
            acc_xor = 1'b1;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) state_nxt = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (bit_valid) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            data_nxt  = shreg;
            calc_nxt  = acc;
            ok_nxt    = (acc == bit_in);
            done_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          acc_clr   = 1'b1;
        end
      endcase
    end
  end

`ifdef ERR_CNT_EN
  // Saturating count of frames that completed with a parity mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (done_nxt && !ok_nxt && (err_cnt != ERR_CNT_MAX)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule : serial_parity_checker

// File: tb/tb_serial_parity_checker.sv
// Self-checking bench for serial_parity_checker: vector table, corner-case
// sequences and a done-driven scoreboard. Build with ERR_CNT_EN to check err_cnt.
module tb_serial_parity_checker;

  localparam int unsigned DATA_W = 8;

  logic clk = 1'b0;
  logic rst, bit_valid, bit_in, frame_abort;
  logic busy, done, parity_ok, calc_parity;
  logic [DATA_W-1:0] data_out;
`ifdef ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_calc;
    logic       exp_ok;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       calc;
    logic       ok;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  vec_t vecs[7];
  int n_pass = 0;
  int n_total = 0;
  int done_seen = 0;
  int err_model = 0;
  bit mon_en = 1'b0;

  serial_parity_checker #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .frame_abort (frame_abort),
    .busy        (busy),
    .done        (done),
    .parity_ok   (parity_ok),
    .calc_parity (calc_parity),
    .data_out    (data_out)
`ifdef ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Scoreboard: every done pulse must match the oldest pending frame.
  always @(negedge clk) begin
    if (mon_en && done === 1'b1) begin
      done_seen++;
      chk("busy_low_with_done", 32'(busy), 32'd0);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL spurious_done: got done=1 required done=0 (no frame pending)");
      end else begin
        e_mon = sb.pop_front();
        chk("sb_data_out", 32'(data_out), 32'(e_mon.data));
        chk("sb_calc_parity", 32'(calc_parity), 32'(e_mon.calc));
        chk("sb_parity_ok", 32'(parity_ok), 32'(e_mon.ok));
      end
    end
  end

  // One clock cycle of input drive, returning 1 time unit after the edge.
  task automatic drive(input logic v, input logic b, input logic a);
    bit_valid   = v;
    bit_in      = b;
    frame_abort = a;
    @(posedge clk);
    #1;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    frame_abort = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int gap,
                            input logic [7:0] ed, input logic ec, input logic eo);
    exp_t e;
    e.data = ed; e.calc = ec; e.ok = eo;
    sb.push_back(e);
    if (!eo) err_model++;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, d[i], 1'b0);
      repeat (gap) drive(1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, p, 1'b0);
    chk("done_latency", 32'(done), 32'd1);
  endtask

  task automatic chk_err(input string name);
`ifdef ERR_CNT_EN
    chk(name, 32'(err_cnt), (err_model > 255) ? 32'd255 : 32'(err_model));
`else
    if (name.len() == 0) $display("note: empty check name");
`endif
  endtask

  initial begin
    int snap;
    logic [7:0] rd;
    logic rp;

    vecs[0] = '{8'hA5, 1'b0, 0, 8'hA5, 1'b0, 1'b1};
    vecs[1] = '{8'h07, 1'b0, 0, 8'h07, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 3, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 0, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 1'b0, 1, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 2, 8'h80, 1'b1, 1'b1};

    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; frame_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_parity_ok", 32'(parity_ok), 32'd0);
    chk("rst_calc_parity", 32'(calc_parity), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk_err("rst_err_cnt");
    rst = 1'b0;
    mon_en = 1'b1;

    // First bit moves the FSM out of IDLE; done drops one cycle after it pulses.
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].gap,
                 vecs[i].exp_data, vecs[i].exp_calc, vecs[i].exp_ok);
      drive(1'b0, 1'b0, 1'b0);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk_err("table_err_cnt");
    end

    // Abort after 4 bits of 8'hFF (with a bit in the abort cycle), then 8'h81.
    drive(1'b1, 1'b1, 1'b0);
    chk("busy_after_first_bit", 32'(busy), 32'd1);
    repeat (3) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_holds_data", 32'(data_out), 32'h80);
    chk("abort_holds_ok", 32'(parity_ok), 32'd1);
    drive(1'b0, 1'b0, 1'b1);
    chk("idle_abort_busy", 32'(busy), 32'd0);
    send_frame(8'h81, 1'b0, 0, 8'h81, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // Reset mid-frame after 5 bits, then a clean 8'hA5 frame.
    repeat (5) drive(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    err_model = 0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_parity_ok", 32'(parity_ok), 32'd0);
    chk("midrst_calc_parity", 32'(calc_parity), 32'd0);
    chk_err("midrst_err_cnt");
    send_frame(8'hA5, 1'b0, 0, 8'hA5, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // Random frames with parity from a reduction-XOR model.
    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      send_frame(rd, rp, int'($urandom_range(0, 2)), rd, ^rd, (^rd) == rp);
    end
    drive(1'b0, 1'b0, 1'b0);
    chk_err("random_err_cnt");

    // 260 back-to-back bad-parity frames, next bit presented during done.
    snap = done_seen;
    for (int i = 0; i < 260; i++) send_frame(8'h07, 1'b0, 0, 8'h07, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("b2b_done_count", 32'(done_seen - snap), 32'd260);
    chk_err("b2b_err_cnt_sat");
    send_frame(8'h07, 1'b0, 0, 8'h07, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk_err("err_cnt_hold");

    drive(1'b0, 1'b0, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_serial_parity_checker
